// File: rtl/coherence_ctrl_if.sv
// Cache/RAM side bundle of the dual-core MSI coherence controller.
interface coherence_ctrl_if #(
  parameter int unsigned CPUS   = 2,
  parameter int unsigned WORD_W = 32
);
  logic [CPUS-1:0]              iREN;
  logic [CPUS-1:0][WORD_W-1:0]  iaddr;
  logic [CPUS-1:0]              iwait;
  logic [CPUS-1:0][WORD_W-1:0]  iload;
  logic [CPUS-1:0]              dREN;
  logic [CPUS-1:0]              dWEN;
  logic [CPUS-1:0][WORD_W-1:0]  daddr;
  logic [CPUS-1:0][WORD_W-1:0]  dstore;
  logic [CPUS-1:0]              dwait;
  logic [CPUS-1:0][WORD_W-1:0]  dload;
  logic [CPUS-1:0]              cctrans;
  logic [CPUS-1:0]              ccwrite;
  logic [CPUS-1:0]              ccwait;
  logic [CPUS-1:0]              ccinv;
  logic [CPUS-1:0][WORD_W-1:0]  ccsnoopaddr;
  logic                         ramREN;
  logic                         ramWEN;
  logic [WORD_W-1:0]            ramaddr;
  logic [WORD_W-1:0]            ramstore;
  logic [WORD_W-1:0]            ramload;
  logic [1:0]                   ramstate;

  // Caches and RAM drive requests/data; they see stalls, fills and snoops.
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
    input  ramREN, ramWEN, ramaddr, ramstore
  );

  // Controller side.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
    output ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_ctrl.sv
// Bus-side coherence responder: arbitrates dcache/icache traffic of two cores,
// runs the snoop handshake and moves two-word blocks cache-to-cache or from RAM.
module coherence_ctrl #(
  parameter int unsigned CPUS   = 2,
  parameter int unsigned WORD_W = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  coherence_ctrl_if.slave bus
);

  localparam logic [1:0]        RAM_ACCESS = 2'b10;
  localparam logic [WORD_W-1:0] ZERO_WORD  = '0;

  typedef enum logic [2:0] {
    IDLE, SNOOP, XFER1, XFER2, MEM1, MEM2, WB, IFETCH
  } state_t;

  state_t          state, next_state;
  logic            req, next_req;
  logic            rr, next_rr;
  logic            snp;
  logic            access;
  logic            grant;
  logic            win;
  logic [CPUS-1:0] wb_mask;
  logic [CPUS-1:0] snoop_mask;

  assign snp        = ~req;
  assign access     = (bus.ramstate == RAM_ACCESS);
  assign wb_mask    = bus.dWEN & ~bus.cctrans;
  assign snoop_mask = bus.cctrans & bus.dREN;

  // Tie goes to the round-robin bit, otherwise to the single requester.
  function automatic logic pick(input logic [CPUS-1:0] mask, input logic prio);
    return (&mask) ? prio : mask[1];
  endfunction

  // State, owner and round-robin priority registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      req   <= 1'b0;
      rr    <= 1'b0;
    end else begin
      state <= next_state;
      req   <= next_req;
      rr    <= next_rr;
    end
  end

  // Arbitration, transaction sequencing and bus outputs.
  always_comb begin
    next_state      = state;
    next_req        = req;
    next_rr         = rr;
    grant           = 1'b0;
    win             = 1'b0;
    bus.iwait       = '1;
    bus.iload       = '0;
    bus.dwait       = '1;
    bus.dload       = '0;
    bus.ccwait      = '0;
    bus.ccinv       = '0;
    bus.ccsnoopaddr = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = ZERO_WORD;
    bus.ramstore    = ZERO_WORD;

    case (state)
      IDLE: begin
        // Writebacks first so dirty victims never starve behind new misses.
        if (|wb_mask) begin
          grant      = 1'b1;
          win        = pick(wb_mask, rr);
          next_state = WB;
        end else if (|snoop_mask) begin
          grant      = 1'b1;
          win        = pick(snoop_mask, rr);
          next_state = SNOOP;
        end else if (|bus.iREN) begin
          grant      = 1'b1;
          win        = pick(bus.iREN, rr);
          next_state = IFETCH;
        end
        if (grant) begin
          next_req = win;
          next_rr  = ~win;
        end
      end

      SNOOP: begin
        bus.ccwait[snp]      = 1'b1;
        bus.ccsnoopaddr[snp] = bus.daddr[req];
        bus.ccinv[snp]       = bus.ccwrite[req];
        if (bus.cctrans[snp]) begin
          next_state = bus.ccwrite[snp] ? XFER1 : MEM1;
        end
      end

      XFER1, XFER2: begin
        // Modified block goes to requester and RAM on the same RAM write.
        bus.ccwait[snp] = 1'b1;
        bus.ramWEN      = 1'b1;
        bus.ramaddr     = bus.daddr[snp];
        bus.ramstore    = bus.dstore[snp];
        bus.dload[req]  = bus.dstore[snp];
        if (access) begin
          bus.dwait[req] = 1'b0;
          bus.dwait[snp] = 1'b0;
          next_state     = (state == XFER1) ? XFER2 : IDLE;
        end
      end

      MEM1, MEM2: begin
        bus.ramREN     = 1'b1;
        bus.ramaddr    = bus.daddr[req];
        bus.dload[req] = bus.ramload;
        if (access) begin
          bus.dwait[req] = 1'b0;
          next_state     = (state == MEM1) ? MEM2 : IDLE;
        end
      end

      WB: begin
        // The cache keeps dWEN up across both words; dropping it ends the burst.
        bus.ramWEN   = 1'b1;
        bus.ramaddr  = bus.daddr[req];
        bus.ramstore = bus.dstore[req];
        if (access) begin
          bus.dwait[req] = 1'b0;
        end
        if (!bus.dWEN[req]) begin
          next_state = IDLE;
        end
      end

      IFETCH: begin
        bus.ramREN     = 1'b1;
        bus.ramaddr    = bus.iaddr[req];
        bus.iload[req] = bus.ramload;
        if (access) begin
          bus.iwait[req] = 1'b0;
          next_state     = IDLE;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_coherence_ctrl.sv
// Self-checking bench for coherence_ctrl: directed vector table, a reset
// sequence and randomized traffic against a transaction-level model.
module tb_coherence_ctrl;

  localparam logic [31:0]  Z          = 32'h0;
  localparam logic [265:0] RESET_OUTS = {2'b11, 64'h0, 2'b11, 198'h0};

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  coherence_ctrl_if #(.CPUS(2), .WORD_W(32)) bus ();

  coherence_ctrl #(.CPUS(2), .WORD_W(32)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  dren, dwen, cct, ccw, iren;
    logic [31:0] da0, da1, ds0, ds1;
    logic [1:0]  rs;
    logic [31:0] rl;
    logic        rren, rwen;
    logic [31:0] raddr, rstore;
    logic [1:0]  dw, iw, cw, ci;
    logic [31:0] dl0, dl1, il0, il1;
  } vec_t;

  typedef enum int {K_NONE, K_SNOOP, K_C2C, K_MEM, K_WB, K_IF} kind_t;

  kind_t m_kind;
  logic  m_owner;
  logic  m_prio;
  int    m_word;

  vec_t tbl[$];
  vec_t hand[$];

  function automatic logic [265:0] dut_outs();
    return {bus.iwait, bus.iload[1], bus.iload[0], bus.dwait, bus.dload[1], bus.dload[0],
            bus.ccwait, bus.ccinv, bus.ccsnoopaddr[1], bus.ccsnoopaddr[0],
            bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore};
  endfunction

  function automatic logic [201:0] tbl_outs();
    return {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.dwait, bus.iwait,
            bus.ccwait, bus.ccinv, bus.dload[0], bus.dload[1], bus.iload[0], bus.iload[1]};
  endfunction

  function automatic logic [201:0] tbl_exp(input vec_t v);
    return {v.rren, v.rwen, v.raddr, v.rstore, v.dw, v.iw, v.cw, v.ci,
            v.dl0, v.dl1, v.il0, v.il1};
  endfunction

  task automatic check(input string name, input logic [265:0] got, input logic [265:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.dREN      = v.dren;
    bus.dWEN      = v.dwen;
    bus.cctrans   = v.cct;
    bus.ccwrite   = v.ccw;
    bus.iREN      = v.iren;
    bus.daddr[0]  = v.da0;
    bus.daddr[1]  = v.da1;
    bus.dstore[0] = v.ds0;
    bus.dstore[1] = v.ds1;
    bus.ramstate  = v.rs;
    bus.ramload   = v.rl;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    drive(v);
    #2;
    check(name, 266'(tbl_outs()), 266'(tbl_exp(v)));
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    bus.dREN     = 2'b00;
    bus.dWEN     = 2'b00;
    bus.cctrans  = 2'b00;
    bus.ccwrite  = 2'b00;
    bus.iREN     = 2'b00;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramstate = 2'b00;
    bus.ramload  = 32'h0;
    bus.iaddr[0] = 32'h400;
    bus.iaddr[1] = 32'h500;
  endtask

  // Expected outputs of the transaction the model currently holds.
  function automatic logic [265:0] model_out();
    logic [1:0]  iw, dw, cw, ci;
    logic [31:0] il[2];
    logic [31:0] dl[2];
    logic [31:0] csa[2];
    logic        ren, wen, r, s, acc;
    logic [31:0] addr, st;
    iw = 2'b11; dw = 2'b11; cw = 2'b00; ci = 2'b00;
    ren = 1'b0; wen = 1'b0; addr = 32'h0; st = 32'h0;
    for (int k = 0; k < 2; k++) begin
      il[k] = 32'h0; dl[k] = 32'h0; csa[k] = 32'h0;
    end
    r   = m_owner;
    s   = ~m_owner;
    acc = (bus.ramstate == 2'b10);
    case (m_kind)
      K_SNOOP: begin
        cw[s] = 1'b1; csa[s] = bus.daddr[r]; ci[s] = bus.ccwrite[r];
      end
      K_C2C: begin
        cw[s] = 1'b1; wen = 1'b1; addr = bus.daddr[s]; st = bus.dstore[s];
        dl[r] = bus.dstore[s];
        if (acc) dw = 2'b00;
      end
      K_MEM: begin
        ren = 1'b1; addr = bus.daddr[r]; dl[r] = bus.ramload;
        if (acc) dw[r] = 1'b0;
      end
      K_WB: begin
        wen = 1'b1; addr = bus.daddr[r]; st = bus.dstore[r];
        if (acc) dw[r] = 1'b0;
      end
      K_IF: begin
        ren = 1'b1; addr = bus.iaddr[r]; il[r] = bus.ramload;
        if (acc) iw[r] = 1'b0;
      end
      default: ;
    endcase
    return {iw, il[1], il[0], dw, dl[1], dl[0], cw, ci, csa[1], csa[0], ren, wen, addr, st};
  endfunction

  task automatic model_grant(input kind_t k, input logic [1:0] mask);
    logic w;
    w       = (mask == 2'b11) ? m_prio : (mask == 2'b10);
    m_kind  = k;
    m_owner = w;
    m_prio  = ~w;
    m_word  = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic       acc, r, s;
    logic [1:0] wbm, snm;
    acc = (bus.ramstate == 2'b10);
    r   = m_owner;
    s   = ~m_owner;
    wbm = bus.dWEN & ~bus.cctrans;
    snm = bus.cctrans & bus.dREN;
    case (m_kind)
      K_NONE: begin
        if (wbm != 2'b00)           model_grant(K_WB, wbm);
        else if (snm != 2'b00)      model_grant(K_SNOOP, snm);
        else if (bus.iREN != 2'b00) model_grant(K_IF, bus.iREN);
      end
      K_SNOOP: if (bus.cctrans[s]) begin
        m_kind = bus.ccwrite[s] ? K_C2C : K_MEM;
        m_word = 0;
      end
      K_C2C, K_MEM: if (acc) begin
        if (m_word == 1) m_kind = K_NONE;
        else m_word = 1;
      end
      K_WB: if (!bus.dWEN[r]) m_kind = K_NONE;
      K_IF: if (acc) m_kind = K_NONE;
      default: m_kind = K_NONE;
    endcase
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // Read miss core0 @0x100, core1 clean -> two RAM reads.
    tbl.push_back(vec_t'{2'b01,2'b00,2'b01,2'b00,2'b00, 32'h100,Z,Z,Z, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    tbl.push_back(vec_t'{2'b01,2'b00,2'b11,2'b00,2'b00, 32'h100,Z,Z,Z, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b10,2'b00, Z,Z,Z,Z});
    tbl.push_back(vec_t'{2'b01,2'b00,2'b00,2'b00,2'b00, 32'h100,Z,Z,Z, 2'b00,32'h11, 1'b1,1'b0,32'h100,Z, 2'b11,2'b11,2'b00,2'b00, 32'h11,Z,Z,Z});
    tbl.push_back(vec_t'{2'b01,2'b00,2'b00,2'b00,2'b00, 32'h100,Z,Z,Z, 2'b10,32'hAAAA0001, 1'b1,1'b0,32'h100,Z, 2'b10,2'b11,2'b00,2'b00, 32'hAAAA0001,Z,Z,Z});
    tbl.push_back(vec_t'{2'b01,2'b00,2'b00,2'b00,2'b00, 32'h104,Z,Z,Z, 2'b10,32'hAAAA0002, 1'b1,1'b0,32'h104,Z, 2'b10,2'b11,2'b00,2'b00, 32'hAAAA0002,Z,Z,Z});
    tbl.push_back(vec_t'{2'b00,2'b00,2'b00,2'b00,2'b00, Z,Z,Z,Z, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    // Read-exclusive core1 @0x200, core0 Modified -> cache-to-cache plus RAM write.
    tbl.push_back(vec_t'{2'b10,2'b00,2'b10,2'b10,2'b00, Z,32'h200,Z,Z, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    tbl.push_back(vec_t'{2'b10,2'b00,2'b11,2'b11,2'b00, 32'h200,32'h200,32'hDEAD,Z, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b01,2'b01, Z,Z,Z,Z});
    tbl.push_back(vec_t'{2'b10,2'b00,2'b00,2'b10,2'b00, 32'h200,32'h200,32'hDEAD,Z, 2'b01,Z, 1'b0,1'b1,32'h200,32'hDEAD, 2'b11,2'b11,2'b01,2'b00, Z,32'hDEAD,Z,Z});
    tbl.push_back(vec_t'{2'b10,2'b00,2'b00,2'b10,2'b00, 32'h200,32'h200,32'hDEAD,Z, 2'b10,Z, 1'b0,1'b1,32'h200,32'hDEAD, 2'b00,2'b11,2'b01,2'b00, Z,32'hDEAD,Z,Z});
    tbl.push_back(vec_t'{2'b10,2'b00,2'b00,2'b10,2'b00, 32'h204,32'h204,32'hBEEF,Z, 2'b10,Z, 1'b0,1'b1,32'h204,32'hBEEF, 2'b00,2'b11,2'b01,2'b00, Z,32'hBEEF,Z,Z});
    tbl.push_back(vec_t'{2'b00,2'b00,2'b00,2'b00,2'b00, Z,Z,Z,Z, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    // Core0 dcache miss and core1 ifetch together: data first.
    tbl.push_back(vec_t'{2'b01,2'b00,2'b01,2'b00,2'b10, 32'h180,Z,Z,Z, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    tbl.push_back(vec_t'{2'b01,2'b00,2'b11,2'b00,2'b10, 32'h180,Z,Z,Z, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b10,2'b00, Z,Z,Z,Z});
    tbl.push_back(vec_t'{2'b01,2'b00,2'b00,2'b00,2'b10, 32'h180,Z,Z,Z, 2'b10,32'h5, 1'b1,1'b0,32'h180,Z, 2'b10,2'b11,2'b00,2'b00, 32'h5,Z,Z,Z});
    tbl.push_back(vec_t'{2'b01,2'b00,2'b00,2'b00,2'b10, 32'h184,Z,Z,Z, 2'b10,32'h6, 1'b1,1'b0,32'h184,Z, 2'b10,2'b11,2'b00,2'b00, 32'h6,Z,Z,Z});
    tbl.push_back(vec_t'{2'b00,2'b00,2'b00,2'b00,2'b10, Z,Z,Z,Z, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    tbl.push_back(vec_t'{2'b00,2'b00,2'b00,2'b00,2'b10, Z,Z,Z,Z, 2'b00,32'h77, 1'b1,1'b0,32'h500,Z, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,32'h77});
    tbl.push_back(vec_t'{2'b00,2'b00,2'b00,2'b00,2'b10, Z,Z,Z,Z, 2'b10,32'h88, 1'b1,1'b0,32'h500,Z, 2'b11,2'b01,2'b00,2'b00, Z,Z,Z,32'h88});
    // Both cores miss in the same cycle with rr=0: core0 then core1.
    tbl.push_back(vec_t'{2'b11,2'b00,2'b11,2'b00,2'b00, 32'h600,32'h700,Z,Z, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    tbl.push_back(vec_t'{2'b11,2'b00,2'b11,2'b00,2'b00, 32'h600,32'h700,Z,Z, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b10,2'b00, Z,Z,Z,Z});
    tbl.push_back(vec_t'{2'b11,2'b00,2'b11,2'b00,2'b00, 32'h600,32'h700,Z,Z, 2'b10,32'h1, 1'b1,1'b0,32'h600,Z, 2'b10,2'b11,2'b00,2'b00, 32'h1,Z,Z,Z});
    tbl.push_back(vec_t'{2'b11,2'b00,2'b11,2'b00,2'b00, 32'h604,32'h700,Z,Z, 2'b10,32'h2, 1'b1,1'b0,32'h604,Z, 2'b10,2'b11,2'b00,2'b00, 32'h2,Z,Z,Z});
    tbl.push_back(vec_t'{2'b10,2'b00,2'b10,2'b00,2'b00, Z,32'h700,Z,Z, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    tbl.push_back(vec_t'{2'b10,2'b00,2'b11,2'b00,2'b00, Z,32'h700,Z,Z, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b01,2'b00, Z,Z,Z,Z});
    tbl.push_back(vec_t'{2'b10,2'b00,2'b00,2'b00,2'b00, Z,32'h700,Z,Z, 2'b10,32'h3, 1'b1,1'b0,32'h700,Z, 2'b01,2'b11,2'b00,2'b00, Z,32'h3,Z,Z});
    tbl.push_back(vec_t'{2'b10,2'b00,2'b00,2'b00,2'b00, Z,32'h704,Z,Z, 2'b10,32'h4, 1'b1,1'b0,32'h704,Z, 2'b01,2'b11,2'b00,2'b00, Z,32'h4,Z,Z});
    // Core0 two-word writeback @0x300 with three wait cycles per word.
    tbl.push_back(vec_t'{2'b00,2'b01,2'b00,2'b00,2'b00, 32'h300,Z,32'h31,Z, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    for (int k = 0; k < 3; k++)
      tbl.push_back(vec_t'{2'b00,2'b01,2'b00,2'b00,2'b00, 32'h300,Z,32'h31,Z, 2'b00,Z, 1'b0,1'b1,32'h300,32'h31, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    tbl.push_back(vec_t'{2'b00,2'b01,2'b00,2'b00,2'b00, 32'h300,Z,32'h31,Z, 2'b10,Z, 1'b0,1'b1,32'h300,32'h31, 2'b10,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    for (int k = 0; k < 3; k++)
      tbl.push_back(vec_t'{2'b00,2'b01,2'b00,2'b00,2'b00, 32'h304,Z,32'h32,Z, 2'b00,Z, 1'b0,1'b1,32'h304,32'h32, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    tbl.push_back(vec_t'{2'b00,2'b01,2'b00,2'b00,2'b00, 32'h304,Z,32'h32,Z, 2'b10,Z, 1'b0,1'b1,32'h304,32'h32, 2'b10,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    tbl.push_back(vec_t'{2'b00,2'b00,2'b00,2'b00,2'b00, 32'h304,Z,32'h32,Z, 2'b00,Z, 1'b0,1'b1,32'h304,32'h32, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    tbl.push_back(vec_t'{2'b00,2'b00,2'b00,2'b00,2'b00, Z,Z,Z,Z, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    // Core0 read-exclusive up to XFER1 (rr ends at 1), then reset.
    hand.push_back(vec_t'{2'b01,2'b00,2'b01,2'b01,2'b00, 32'h900,Z,Z,Z, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    hand.push_back(vec_t'{2'b01,2'b00,2'b11,2'b11,2'b00, 32'h900,32'h900,Z,32'h55, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b10,2'b10, Z,Z,Z,Z});
    hand.push_back(vec_t'{2'b01,2'b00,2'b00,2'b01,2'b00, 32'h900,32'h900,Z,32'h55, 2'b01,Z, 1'b0,1'b1,32'h900,32'h55, 2'b11,2'b11,2'b10,2'b00, 32'h55,Z,Z,Z});
    // After reset rr is 0 again, so a writeback tie goes to core0.
    hand.push_back(vec_t'{2'b00,2'b11,2'b00,2'b00,2'b00, 32'hA00,32'hB00,32'h1,32'h2, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    hand.push_back(vec_t'{2'b00,2'b11,2'b00,2'b00,2'b00, 32'hA00,32'hB00,32'h1,32'h2, 2'b10,Z, 1'b0,1'b1,32'hA00,32'h1, 2'b10,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    hand.push_back(vec_t'{2'b00,2'b00,2'b00,2'b00,2'b00, 32'hA00,32'hB00,32'h1,32'h2, 2'b00,Z, 1'b0,1'b1,32'hA00,32'h1, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,Z});
    hand.push_back(vec_t'{2'b00,2'b00,2'b00,2'b00,2'b00, Z,Z,Z,Z, 2'b00,Z, 1'b0,1'b0,Z,Z, 2'b11,2'b11,2'b00,2'b00, Z,Z,Z,Z});

    nrst = 1'b0;
    zero_inputs();
    #2;
    check("reset", dut_outs(), RESET_OUTS);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    foreach (tbl[i]) run_vec($sformatf("tbl%0d", i), tbl[i]);

    for (int i = 0; i < 3; i++) run_vec($sformatf("hand%0d", i), hand[i]);
    drive(hand[2]);
    nrst = 1'b0;
    #2;
    check("reset_mid_xfer", dut_outs(), RESET_OUTS);
    @(posedge clk);
    #1;
    check("reset_held_edge", dut_outs(), RESET_OUTS);
    zero_inputs();
    nrst = 1'b1;
    for (int i = 3; i < 7; i++) run_vec($sformatf("hand%0d", i), hand[i]);

    // Randomized traffic against the transaction model, from a fresh reset.
    nrst = 1'b0;
    zero_inputs();
    m_kind  = K_NONE;
    m_owner = 1'b0;
    m_prio  = 1'b0;
    m_word  = 0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      bus.dREN    = 2'($urandom);
      bus.cctrans = 2'($urandom);
      bus.ccwrite = 2'($urandom);
      bus.iREN    = 2'($urandom);
      bus.dWEN    = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      for (int k = 0; k < 2; k++) begin
        bus.daddr[k]  = 32'($urandom_range(0, 63)) << 2;
        bus.dstore[k] = $urandom;
        bus.iaddr[k]  = 32'($urandom_range(0, 63)) << 2;
      end
      bus.ramstate = 2'($urandom);
      bus.ramload  = $urandom;
      #2;
      check($sformatf("rand%0d", c), dut_outs(), model_out());
      model_step();
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
